// File: rtl/pixel_ram_arbiter_if.sv
// Pixel RAM arbiter bus: CPU memory-stage port, display fetch port and RAM port.
// The arbiter takes the slave view; the surrounding logic (or bench) takes the master view.
interface pixel_ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_late;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata, disp_late,
        output ram_addr, ram_wdata, ram_wren,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata, disp_late,
        input  ram_addr, ram_wdata, ram_wren,
        output ram_q
    );
endinterface

// File: rtl/pixel_ram_arbiter.sv
// Two-requester arbiter for the single-port pixel RAM (CPU read/write, display read).
// Define ARB_ROUND_ROBIN_EN for alternating conflict priority instead of display-first.
module pixel_ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    pixel_ram_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPU_RD,
        TAG_CPU_WR,
        TAG_DISP
    } tag_t;

    tag_t       t1;
    tag_t       t2;
    logic [3:0] wait_cnt;
    logic       conflict;
    logic       starve;
    logic       cpu_first;
    logic       cpu_win;
    logic       disp_win;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        PTR_DISP,
        PTR_CPU
    } ptr_t;

    ptr_t rr_ptr;
`endif

    // Grants are held low while reset is asserted so nothing is accepted.
    always_comb begin
        conflict = bus.cpu_req & bus.disp_req;
        starve   = (wait_cnt == WAIT_MAX);
`ifdef ARB_ROUND_ROBIN_EN
        cpu_first = starve | (rr_ptr == PTR_CPU);
`else
        cpu_first = starve;
`endif
        cpu_win  = rst_n & bus.cpu_req & (~bus.disp_req | cpu_first);
        disp_win = rst_n & bus.disp_req & ~cpu_win;
    end

    assign bus.cpu_gnt     = cpu_win;
    assign bus.disp_gnt    = disp_win;
    assign bus.cpu_stall   = bus.cpu_req & ~cpu_win;
    assign bus.cpu_rvalid  = (t2 == TAG_CPU_RD);
    assign bus.disp_rvalid = (t2 == TAG_DISP);
    assign bus.cpu_rdata   = bus.ram_q;
    assign bus.disp_rdata  = bus.ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_wren  <= 1'b0;
            t1            <= TAG_NONE;
            t2            <= TAG_NONE;
            wait_cnt      <= '0;
            bus.disp_late <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr        <= PTR_DISP;
`endif
        end else begin
            if (cpu_win) begin
                bus.ram_addr  <= bus.cpu_addr;
                bus.ram_wdata <= bus.cpu_wdata;
                bus.ram_wren  <= bus.cpu_we;
                t1            <= bus.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            end else if (disp_win) begin
                bus.ram_addr  <= bus.disp_addr;
                bus.ram_wren  <= 1'b0;
                t1            <= TAG_DISP;
            end else begin
                bus.ram_wren  <= 1'b0;
                t1            <= TAG_NONE;
            end
            t2 <= t1;

            if (!bus.cpu_req || cpu_win)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 4'd1;

            if (conflict && starve)
                bus.disp_late <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            if (conflict)
                rr_ptr <= cpu_win ? PTR_DISP : PTR_CPU;
`endif
        end
    end
endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a synchronous single-port RAM model.
// Conflict expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_pixel_ram_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    pixel_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pixel_ram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // RAM samples the registered address at each edge; data appears after that edge.
    always @(posedge clk) begin
        if (bus.ram_wren)
            mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c_req, input logic c_we, input logic [ADDR_W-1:0] c_addr,
                         input logic [DATA_W-1:0] c_wd, input logic d_req,
                         input logic [ADDR_W-1:0] d_addr);
        bus.cpu_req   = c_req;
        bus.cpu_we    = c_we;
        bus.cpu_addr  = c_addr;
        bus.cpu_wdata = c_wd;
        bus.disp_req  = d_req;
        bus.disp_addr = d_addr;
    endtask

    initial begin
        logic exp_cpu;
        logic exp_late;

        // Reset with both requesters active
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0033, 8'h00, 1'b1, 16'h0044);
        repeat (3) @(negedge clk);
        #1;
        chk("rst ram_addr",    bus.ram_addr,    32'h0);
        chk("rst ram_wdata",   bus.ram_wdata,   32'h0);
        chk("rst ram_wren",    bus.ram_wren,    32'h0);
        chk("rst cpu_rvalid",  bus.cpu_rvalid,  32'h0);
        chk("rst disp_rvalid", bus.disp_rvalid, 32'h0);
        chk("rst disp_late",   bus.disp_late,   32'h0);
        chk("rst cpu_gnt",     bus.cpu_gnt,     32'h0);
        chk("rst disp_gnt",    bus.disp_gnt,    32'h0);

        // Continuous conflict starting from reset release
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1)
                rst_n = 1'b1;
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_cpu  = (i % 2 == 0);
            exp_late = 1'b0;
`else
            exp_cpu  = (i % 5 == 0);
            exp_late = (i >= 6);
`endif
            chk($sformatf("conf cpu_gnt c%0d", i),   bus.cpu_gnt,   {31'h0, exp_cpu});
            chk($sformatf("conf disp_gnt c%0d", i),  bus.disp_gnt,  {31'h0, ~exp_cpu});
            chk($sformatf("conf cpu_stall c%0d", i), bus.cpu_stall, {31'h0, ~exp_cpu});
            chk($sformatf("conf disp_late c%0d", i), bus.disp_late, {31'h0, exp_late});
            chk($sformatf("conf ram_wren c%0d", i),  bus.ram_wren,  32'h0);
        end

`ifndef ARB_ROUND_ROBIN_EN
        // Dropping cpu_req for one cycle clears the wait counter
        for (int j = 11; j <= 19; j++) begin
            @(negedge clk);
            drive(j != 14, 1'b0, 16'h0033, 8'h00, 1'b1, 16'h0044);
            #1;
            exp_cpu = (j == 19);
            chk($sformatf("clr cpu_gnt c%0d", j),  bus.cpu_gnt,  {31'h0, exp_cpu});
            chk($sformatf("clr disp_gnt c%0d", j), bus.disp_gnt, {31'h0, ~exp_cpu});
        end
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        #1;
        chk("idle cpu_rvalid",  bus.cpu_rvalid,  32'h0);
        chk("idle disp_rvalid", bus.disp_rvalid, 32'h0);
        chk("idle ram_wren",    bus.ram_wren,    32'h0);
        chk("idle cpu_stall",   bus.cpu_stall,   32'h0);

        // CPU write then read-after-write to 0x0010
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0010, 8'h5A, 1'b0, 16'h0000);
        #1;
        chk("wr cpu_gnt",   bus.cpu_gnt,   32'h1);
        chk("wr cpu_stall", bus.cpu_stall, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0000);
        #1;
        chk("wr ram_addr",  bus.ram_addr,  32'h0010);
        chk("wr ram_wdata", bus.ram_wdata, 32'h5A);
        chk("wr ram_wren",  bus.ram_wren,  32'h1);
        chk("rd cpu_gnt",   bus.cpu_gnt,   32'h1);
        chk("rd cpu_stall", bus.cpu_stall, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        #1;
        chk("rd ram_wren",      bus.ram_wren,   32'h0);
        chk("rd ram_addr",      bus.ram_addr,   32'h0010);
        chk("rd cpu_rvalid e1", bus.cpu_rvalid, 32'h0);
        @(negedge clk);
        #1;
        chk("rd cpu_rvalid e2",  bus.cpu_rvalid,  32'h1);
        chk("rd cpu_rdata",      bus.cpu_rdata,   32'h5A);
        chk("rd disp_rvalid e2", bus.disp_rvalid, 32'h0);
        @(negedge clk);
        #1;
        chk("rd cpu_rvalid e3", bus.cpu_rvalid, 32'h0);

        // Preload two locations, then interleave display and CPU reads
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0100, 8'hA1, 1'b0, 16'h0000);
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0200, 8'hB2, 1'b0, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0100);
        #1;
        chk("il disp_gnt", bus.disp_gnt, 32'h1);
        chk("il cpu_gnt0", bus.cpu_gnt,  32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 16'h0000);
        #1;
        chk("il cpu_gnt",      bus.cpu_gnt,   32'h1);
        chk("il cpu_stall",    bus.cpu_stall, 32'h0);
        chk("il ram_addr disp", bus.ram_addr, 32'h0100);
        chk("il ram_wren disp", bus.ram_wren, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        #1;
        chk("il ram_addr cpu", bus.ram_addr,    32'h0200);
        chk("il disp_rvalid",  bus.disp_rvalid, 32'h1);
        chk("il disp_rdata",   bus.disp_rdata,  32'hA1);
        chk("il cpu_rvalid0",  bus.cpu_rvalid,  32'h0);
        @(negedge clk);
        #1;
        chk("il cpu_rvalid",   bus.cpu_rvalid,  32'h1);
        chk("il cpu_rdata",    bus.cpu_rdata,   32'hB2);
        chk("il disp_rvalid0", bus.disp_rvalid, 32'h0);
        @(negedge clk);
        #1;
        chk("il cpu_rvalid end",  bus.cpu_rvalid,  32'h0);
        chk("il disp_rvalid end", bus.disp_rvalid, 32'h0);

        // Async reset between accept edge and the RAM sample edge
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0100);
        #1;
        chk("ar disp_gnt", bus.disp_gnt, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar ram_wren",    bus.ram_wren,    32'h0);
        chk("ar ram_addr",    bus.ram_addr,    32'h0);
        chk("ar disp_rvalid", bus.disp_rvalid, 32'h0);
        chk("ar disp_late",   bus.disp_late,   32'h0);
        chk("ar disp_gnt0",   bus.disp_gnt,    32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("ar post disp_rvalid %0d", k), bus.disp_rvalid, 32'h0);
            chk($sformatf("ar post ram_wren %0d", k),    bus.ram_wren,    32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_ram_arbiter.md
Name: pixel_ram_arbiter

Overview:
- Shares the single-port pixel RAM between two requesters: the CPU memory stage (reads and writes) and the display scan-out engine (reads only).
- Arbitrates requests each cycle and drives the RAM port through registers.
- Returns the RAM read data to whichever requester issued the read, tagged so it reaches the correct one.
- Sits between the Memory-stage data path, the display pixel fetch logic and the RAM; stalls the CPU pipeline while the CPU is not granted.

Parameters:
ADDR_W, 16, pixel RAM address width
DATA_W, 8, pixel data width
MAX_WAIT, 4, consecutive denied CPU cycles after which the CPU is forced to win (1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request; held until granted
cpu_we  input  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  combinational; access accepted at this edge
cpu_stall  output  1  combinational; cpu_req & ~cpu_gnt, drives the pipeline hold
cpu_rvalid  output  1  CPU read data valid (1-cycle pulse)
cpu_rdata  output  DATA_W  CPU read data
disp_req  input  1  display read request; held until granted
disp_addr  input  ADDR_W  display pixel address
disp_gnt  output  1  combinational grant
disp_rvalid  output  1  display read data valid (1-cycle pulse)
disp_rdata  output  DATA_W  display read data
disp_late  output  1  sticky; set when a display request is denied by the starvation override
ram_addr  output  ADDR_W  registered RAM address
ram_wdata  output  DATA_W  registered RAM write data
ram_wren  output  1  registered RAM write enable
ram_q  input  DATA_W  RAM read data, valid one cycle after ram_addr is sampled by the RAM

Behaviour:
Reset (async, rst_n=0):
- ram_addr=0, ram_wdata=0, ram_wren=0.
- Both in-flight tags = NONE; cpu_rvalid=0, disp_rvalid=0.
- Wait counter = 0; disp_late = 0; round-robin pointer = DISP.

Arbitration (combinational, per cycle):
- Only one requester: that requester is granted.
- Both requesting:
  - If wait_cnt == MAX_WAIT, the CPU wins and disp_late is set.
  - Otherwise the display wins.
- The two grants are mutually exclusive.

Transfer (registered, at the edge where req & gnt):
- Register ram_addr and ram_wdata from the winning requester.
- ram_wren = cpu_we for a CPU grant, 0 for a display grant.
- Registered tag t1 = CPU_RD, CPU_WR, DISP or NONE.
- With no grant: ram_wren = 0, t1 = NONE, and ram_addr holds its previous value.

Read return:
- Next edge: t2 <= t1.
- cpu_rvalid = (t2 == CPU_RD); disp_rvalid = (t2 == DISP).
- rdata ports are driven from ram_q; their value is meaningless when the matching rvalid is 0.
- Total latency from the accepting edge E0 to rvalid is 2 cycles (rvalid is high in the cycle after E1).
- CPU writes produce no rvalid. The arbiter is fully pipelined: one grant per cycle, back-to-back.

Wait counter:
- Increments (saturating at MAX_WAIT) on each cycle with cpu_req & ~cpu_gnt.
- Clears to 0 on a CPU grant or when cpu_req = 0.

Boundary rules:
- A write followed by a read to the same address on the next cycle returns the new data; the RAM is read-after-write ordered by port serialisation.
- A request deasserted without a grant is dropped silently.
- rst_n asserted mid-transfer: in-flight reads are discarded and no rvalid is emitted after reset release.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: on a conflict, priority alternates. The pointer flips to the other requester after each conflict grant, and the starvation override still applies.
- Undefined: display-first priority as described above; the pointer logic is absent.

Test Plan:
1. Reset: hold rst_n=0 with both reqs=1 → all outputs 0, no grants. Release → disp_gnt=1 first cycle.
2. CPU write then read: write 0x5A to addr 0x0010, next cycle read 0x0010, disp_req=0 → cpu_stall=0 throughout; cpu_rvalid=1 two cycles after the read grant with cpu_rdata=0x5A.
3. Conflict: both requesting continuously, MAX_WAIT=4 → display granted 4 cycles, CPU granted on cycle 5, disp_late=1, cpu_stall high exactly 4 cycles. Repeats every 5 cycles.
4. Interleaved reads: display addr 0x0100 and CPU addr 0x0200 granted on consecutive cycles → disp_rvalid and cpu_rvalid pulse on consecutive cycles with the matching data; no cross-delivery.
5. Async reset mid-read: grant a display read, assert rst_n=0 between E0 and E1 → disp_rvalid never pulses and ram_wren=0.
6. With ARB_ROUND_ROBIN_EN, both requesting → grants alternate DISP, CPU, DISP, CPU; disp_late stays 0.
